cam_capture: RTL
================

# cam_capture

Camera-side capture stage between the OV5642 parallel pixel port and the camera write FIFO. Registers href/vsync/data on the camera pixel clock and aligns capture to a frame boundary. Selects one byte of each two-byte pixel (luma) and drops bytes beyond the configured active window. Emits a qualified 8-bit pixel stream with start-of-frame and end-of-line markers, line/frame length error flags, and a frame counter.

## Interface
- H_ACTIVE, 640, selected bytes (pixels) per line.
- V_ACTIVE, 480, lines per frame.
- Y_PHASE, 0, byte within each two-byte pair that is kept (0 = first byte after href rise).
- VSYNC_POL, 1, active level of cam_vsync_i.
- cam_pclk  in  1  camera pixel clock; sole clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_done  in  1  camera configuration complete; level, synchronous to cam_pclk.
- cam_href_i  in  1  line valid from camera.
- cam_vsync_i  in  1  frame sync from camera.
- cam_din  in  8  camera data bus.
- pix_valid  out  1  pix_data qualified this cycle (FIFO wr_en).
- pix_data  out  8  selected byte.
- sof  out  1  high with the first pix_valid of a frame (x=0, y=0).
- eol  out  1  high with the pix_valid at x=H_ACTIVE-1.
- line_err  out  1  sticky: a line ended with x != H_ACTIVE.
- frame_err  out  1  sticky: a frame ended with y != V_ACTIVE.
- err_clr  in  1  synchronous clear of line_err/frame_err.
- frame_cnt  out  8  completed frames, wraps 255->0.

## Operation
- Input stage: href, vsync (normalised so vs=1 means active, per VSYNC_POL), din registered every cycle; all logic below uses registered copies and their previous-cycle values.
- State machine:
  - IDLE: no output. cfg_done=1 -> WAIT_VS.
  - WAIT_VS: discard all data. vs falling edge (1->0) -> ACTIVE, x=0, y=0, phase=0.
  - ACTIVE: capture. vs rising edge -> end-of-frame check, -> WAIT_VS.
  - cfg_done=0 in any state -> IDLE next cycle; counters cleared; sticky errors and frame_cnt held.
- Byte phase: toggles on each cycle with href=1; forced to 0 on the cycle after href falls and while href=0.
- Pixel accept in ACTIVE: href=1, phase==Y_PHASE, x<H_ACTIVE, y<V_ACTIVE -> pix_valid=1, pix_data=din, x=x+1. Bytes with x>=H_ACTIVE or y>=V_ACTIVE dropped silently.
- x is 11 bits and saturates at H_ACTIVE; y is 10 bits and saturates at V_ACTIVE.
- Line end (href falling edge in ACTIVE): x != H_ACTIVE -> line_err set; y=y+1 (saturating); x=0.
- Frame end (vs rising edge in ACTIVE): y != V_ACTIVE -> frame_err set; y=V_ACTIVE -> frame_cnt+1. If href=1 at that edge, the line is truncated: its line check is performed too, x cleared, no further output.
- err_clr and a new error in the same cycle: set wins.
- Reset: state=IDLE; x, y, phase, frame_cnt = 0; pix_valid, sof, eol, line_err, frame_err = 0; pix_data = 0.

## Timing
- Latency: cam_din present before rising edge k appears on pix_data after edge k+1 (2 cycles); href/vsync to marker/flag outputs have the same latency.
- pix_valid at most every second cycle (one byte per pair); no backpressure; the downstream FIFO flags overflow.
- sof, eol: single-cycle, coincident with pix_valid.
- line_err/frame_err visible 2 cycles after the offending href/vsync edge at the input pins.
- frame_cnt updates 2 cycles after the vsync assert edge.
- rst asynchronous assert clears all outputs immediately; deassert is sampled on cam_pclk. Reset mid-frame restarts at IDLE; the partial frame is never counted.

## Test plan
- Nominal frame, H_ACTIVE=4, V_ACTIVE=2, Y_PHASE=0: vsync pulse, 2 lines of 8 bytes 0x10..0x17 -> pix_valid x4 per line with data 0x10,0x12,0x14,0x16; sof on first, eol on 4th; frame_cnt 0->1 at next vsync; no errors.
- Startup alignment: cfg_done rises mid-frame -> zero pix_valid until after the next vsync falling edge; first captured pixel carries sof.
- Long/short lines: line of 10 bytes -> 4 pixels output, extra byte dropped, line_err stays 0; line of 6 bytes -> 3 pixels, line_err=1; err_clr -> 0.
- Short frame: vsync after 1 line -> frame_err=1, frame_cnt unchanged; next full frame -> frame_cnt+1.
- Y_PHASE=1 and vsync asserted mid-line: odd bytes selected; line truncated, line_err=1, no pix_valid after vsync.
- rst pulse mid-line: all outputs 0 immediately; frame_cnt=0; capture resumes only after cfg_done and a vsync falling edge.

Source files
------------

// File: rtl/cam_capture.sv
// cam_capture: OV5642 pixel-port capture; frame-aligned luma byte selection with SOF/EOL markers,
// sticky line/frame length errors and a completed-frame counter.
module cam_capture #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int Y_PHASE   = 0,
  parameter int VSYNC_POL = 1
) (
  input  logic       cam_pclk,
  input  logic       rst,
  input  logic       cfg_done,
  input  logic       cam_href_i,
  input  logic       cam_vsync_i,
  input  logic [7:0] cam_din,
  input  logic       err_clr,
  output logic       pix_valid,
  output logic [7:0] pix_data,
  output logic       sof,
  output logic       eol,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [9:0]  VA = 10'(V_ACTIVE);
  localparam logic        YP = 1'(Y_PHASE);
  localparam logic        VP = 1'(VSYNC_POL);
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;
  state_t st, st_n;
  logic href_r, vs_r, href_p, vs_p, ph, ph_n;
  logic [7:0] din_r;
  logic [10:0] x, x_n;
  logic [9:0] y, y_n;
  logic line_end, frame_end, accept, lerr, ferr, fdone;
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      href_r <= 1'b0;
      vs_r   <= 1'b0;
      href_p <= 1'b0;
      vs_p   <= 1'b0;
      din_r  <= '0;
    end else begin
      href_r <= cam_href_i;
      vs_r   <= cam_vsync_i ~^ VP;
      href_p <= href_r;
      vs_p   <= vs_r;
      din_r  <= cam_din;
    end
  end
  assign line_end  = st == ACTIVE && href_p && !href_r;
  assign frame_end = st == ACTIVE && vs_r && !vs_p;
  assign accept    = cfg_done && st == ACTIVE && !frame_end && href_r && ph == YP && x < HA && y < VA;
  always_comb begin
    st_n  = st;
    x_n   = accept ? x + 11'd1 : x;
    y_n   = y;
    ph_n  = href_r & ~ph;
    lerr  = 1'b0;
    ferr  = 1'b0;
    fdone = 1'b0;
    if (!cfg_done) begin
      st_n = IDLE;
      x_n  = '0;
      y_n  = '0;
    end else if (st == IDLE) begin
      st_n = WAIT_VS;
    end else if (st == WAIT_VS) begin
      if (!vs_r && vs_p) begin
        st_n = ACTIVE;
        x_n  = '0;
        y_n  = '0;
        ph_n = 1'b0;
      end
    end else begin
      // a vsync arriving mid-line truncates it: check and clear like a normal line end, but do not count it
      if (line_end || (frame_end && href_r)) begin
        lerr = x != HA;
        x_n  = '0;
      end
      if (line_end && y != VA) y_n = y + 10'd1;
      if (frame_end) begin
        ferr  = y_n != VA;
        fdone = y_n == VA;
        st_n  = WAIT_VS;
      end
    end
  end
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      x         <= '0;
      y         <= '0;
      ph        <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      st        <= st_n;
      x         <= x_n;
      y         <= y_n;
      ph        <= ph_n;
      pix_valid <= accept;
      pix_data  <= accept ? din_r : pix_data;
      sof       <= accept && x == '0 && y == '0;
      eol       <= accept && x == HA - 11'd1;
      line_err  <= lerr | (line_err & ~err_clr);
      frame_err <= ferr | (frame_err & ~err_clr);
      frame_cnt <= frame_cnt + 8'(fdone);
    end
  end
endmodule
